// File: rtl/dispatch_queue_unit_pkg.sv
// Shared decode definitions for dispatch_queue_unit: opcodes, op enumeration and instruction formats.
// Optional feature macro used by the top: DISPATCH_STALL_CNT_EN.
package dispatch_queue_unit_pkg;

  localparam int OPCODE_RANGE = 7;
  localparam int OPENUM_W     = 6;
  localparam int ZERO_ROB     = 0;

  typedef logic [OPCODE_RANGE-1:0] opcode_t;

  localparam opcode_t OPCODE_LUI   = 7'b0110111;
  localparam opcode_t OPCODE_AUIPC = 7'b0010111;
  localparam opcode_t OPCODE_JAL   = 7'b1101111;
  localparam opcode_t OPCODE_JALR  = 7'b1100111;
  localparam opcode_t OPCODE_B     = 7'b1100011;
  localparam opcode_t OPCODE_L     = 7'b0000011;
  localparam opcode_t OPCODE_S     = 7'b0100011;
  localparam opcode_t OPCODE_I     = 7'b0010011;
  localparam opcode_t OPCODE_R     = 7'b0110011;

  typedef enum logic [OPENUM_W-1:0] {
    OP_NOP,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } openum_e;

  // INS_TYPE: encoding format, selects operand usage and immediate layout
  typedef enum logic [2:0] {
    INS_NONE, INS_R, INS_I, INS_S, INS_B, INS_U, INS_J
  } ins_type_e;

  function automatic logic [31:0] imm_of(input ins_type_e fmt, input logic [31:0] inst);
    logic [31:0] imm;
    case (fmt)
      INS_I:   imm = {{20{inst[31]}}, inst[31:20]};
      INS_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      INS_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      INS_U:   imm = {inst[31:12], 12'b0};
      INS_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/dispatch_queue_unit_inst_decoder.sv
// Combinational decoder for the instruction at the head of the dispatch queue.
// Register fields the format does not use are reported as x0.
module inst_decoder
  import dispatch_queue_unit_pkg::*;
(
  input  logic [31:0] inst,
  output openum_e     openum,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        is_ls,
  output logic        use_rs1,
  output logic        use_rs2
);

  opcode_t   opcode;
  logic [2:0] funct3;
  logic      alt;
  ins_type_e fmt;
  logic      has_rd;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign alt    = inst[30];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    openum = OP_NOP;
    fmt    = INS_NONE;
    is_ls  = 1'b0;
    case (opcode)
      OPCODE_LUI:   begin openum = OP_LUI;   fmt = INS_U; end
      OPCODE_AUIPC: begin openum = OP_AUIPC; fmt = INS_U; end
      OPCODE_JAL:   begin openum = OP_JAL;   fmt = INS_J; end
      OPCODE_JALR:  begin openum = OP_JALR;  fmt = INS_I; end
      OPCODE_B: begin
        fmt = INS_B;
        case (funct3)
          3'b000:  openum = OP_BEQ;
          3'b001:  openum = OP_BNE;
          3'b100:  openum = OP_BLT;
          3'b101:  openum = OP_BGE;
          3'b110:  openum = OP_BLTU;
          3'b111:  openum = OP_BGEU;
          default: openum = OP_NOP;
        endcase
      end
      OPCODE_L: begin
        fmt   = INS_I;
        is_ls = 1'b1;
        case (funct3)
          3'b000:  openum = OP_LB;
          3'b001:  openum = OP_LH;
          3'b010:  openum = OP_LW;
          3'b100:  openum = OP_LBU;
          3'b101:  openum = OP_LHU;
          default: openum = OP_NOP;
        endcase
      end
      OPCODE_S: begin
        fmt   = INS_S;
        is_ls = 1'b1;
        case (funct3)
          3'b000:  openum = OP_SB;
          3'b001:  openum = OP_SH;
          3'b010:  openum = OP_SW;
          default: openum = OP_NOP;
        endcase
      end
      OPCODE_I: begin
        fmt = INS_I;
        case (funct3)
          3'b000:  openum = OP_ADDI;
          3'b010:  openum = OP_SLTI;
          3'b011:  openum = OP_SLTIU;
          3'b100:  openum = OP_XORI;
          3'b110:  openum = OP_ORI;
          3'b111:  openum = OP_ANDI;
          3'b001:  openum = OP_SLLI;
          default: openum = alt ? OP_SRAI : OP_SRLI;
        endcase
      end
      OPCODE_R: begin
        fmt = INS_R;
        case (funct3)
          3'b000:  openum = alt ? OP_SUB : OP_ADD;
          3'b001:  openum = OP_SLL;
          3'b010:  openum = OP_SLT;
          3'b011:  openum = OP_SLTU;
          3'b100:  openum = OP_XOR;
          3'b101:  openum = alt ? OP_SRA : OP_SRL;
          3'b110:  openum = OP_OR;
          default: openum = OP_AND;
        endcase
      end
      default: ;
    endcase
  end

  assign use_rs1 = (fmt == INS_R) || (fmt == INS_I) || (fmt == INS_S) || (fmt == INS_B);
  assign use_rs2 = (fmt == INS_R) || (fmt == INS_S) || (fmt == INS_B);
  assign has_rd  = (fmt == INS_R) || (fmt == INS_I) || (fmt == INS_U) || (fmt == INS_J);

  assign rd  = has_rd  ? inst[11:7]  : 5'd0;
  assign rs1 = use_rs1 ? inst[19:15] : 5'd0;
  assign rs2 = use_rs2 ? inst[24:20] : 5'd0;
  assign imm = imm_of(fmt, inst);

endmodule

// File: rtl/dispatch_queue_unit.sv
// In-order dispatcher: instruction FIFO, head decode, operand resolve, single issue per cycle.
// Optional DISPATCH_STALL_CNT_EN adds a saturating stall_cnt output.
module dispatch_queue_unit
  import dispatch_queue_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 4,
  parameter int IQ_DEPTH = 4,
  parameter int NUM_CDB  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rdy,
  input  logic                         if_valid,
  input  logic [31:0]                  if_inst,
  input  logic [XLEN-1:0]              if_pc,
  output logic                         if_ready,
  input  logic                         rob_full,
  input  logic                         rs_full,
  input  logic                         lsb_full,
  output logic [4:0]                   rs1_to_reg,
  output logic [4:0]                   rs2_to_reg,
  input  logic [XLEN-1:0]              V1_from_reg,
  input  logic [XLEN-1:0]              V2_from_reg,
  input  logic [ROB_ID_W-1:0]          Q1_from_reg,
  input  logic [ROB_ID_W-1:0]          Q2_from_reg,
  output logic [ROB_ID_W-1:0]          Q1_to_rob,
  output logic [ROB_ID_W-1:0]          Q2_to_rob,
  input  logic                         Q1_ready_from_rob,
  input  logic                         Q2_ready_from_rob,
  input  logic [XLEN-1:0]              ready_data1_from_rob,
  input  logic [XLEN-1:0]              ready_data2_from_rob,
  input  logic [ROB_ID_W-1:0]          rob_id_from_rob,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_result,
  output logic                         ena_to_rob,
  output logic                         ena_to_reg,
  output logic                         ena_to_rs,
  output logic                         ena_to_lsb,
  output logic [4:0]                   rd_out,
  output logic [ROB_ID_W-1:0]          rob_id_out,
  output logic [OPENUM_W-1:0]          openum_out,
  output logic [XLEN-1:0]              V1_out,
  output logic [XLEN-1:0]              V2_out,
  output logic [ROB_ID_W-1:0]          Q1_out,
  output logic [ROB_ID_W-1:0]          Q2_out,
  output logic [XLEN-1:0]              imm_out,
  output logic [XLEN-1:0]              pc_out,
`ifdef DISPATCH_STALL_CNT_EN
  output logic [31:0]                  stall_cnt,
`endif
  input  logic                         rollback_flag_from_rob
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]     v;
    logic [ROB_ID_W-1:0] q;
  } opnd_t;

  typedef struct packed {
    logic                ena_rob;
    logic                ena_reg;
    logic                ena_rs;
    logic                ena_lsb;
    logic [4:0]          rd;
    logic [ROB_ID_W-1:0] rob_id;
    logic [OPENUM_W-1:0] openum;
    opnd_t               op1;
    opnd_t               op2;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     pc;
  } issue_t;

  logic [31:0]      iq_inst_q [IQ_DEPTH];
  logic [XLEN-1:0]  iq_pc_q   [IQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  issue_t           out_q, out_d;

  openum_e     dec_openum;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_is_ls, dec_use_rs1, dec_use_rs2;
  logic        fifo_empty, push, can_issue, pop;
  opnd_t       opnd1, opnd2;

  inst_decoder u_inst_decoder (
    .inst    (iq_inst_q[head_q]),
    .openum  (dec_openum),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .imm     (dec_imm),
    .is_ls   (dec_is_ls),
    .use_rs1 (dec_use_rs1),
    .use_rs2 (dec_use_rs2)
  );

  assign fifo_empty = (count_q == '0);
  assign if_ready   = (count_q != FULL_CNT);
  // All-zero words are accepted on the handshake but never stored.
  assign push       = rdy & if_valid & if_ready & (if_inst != '0) & ~rollback_flag_from_rob;
  assign can_issue  = ~fifo_empty & ~rob_full & (dec_is_ls ? ~lsb_full : ~rs_full)
                    & ~rollback_flag_from_rob;
  assign pop        = rdy & can_issue;

  assign rs1_to_reg = dec_rs1;
  assign rs2_to_reg = dec_rs2;
  assign Q1_to_rob  = Q1_from_reg;
  assign Q2_to_rob  = Q2_from_reg;

  function automatic opnd_t resolve(
    input logic [ROB_ID_W-1:0]         tag,
    input logic [XLEN-1:0]             reg_val,
    input logic                        rob_rdy,
    input logic [XLEN-1:0]             rob_val,
    input logic [NUM_CDB-1:0]          bus_valid,
    input logic [NUM_CDB*ROB_ID_W-1:0] bus_tag,
    input logic [NUM_CDB*XLEN-1:0]     bus_val
  );
    opnd_t r;
    logic  hit;
    r.v = '0;
    r.q = tag;
    hit = 1'b0;
    if (tag == ROB_ID_W'(ZERO_ROB)) begin
      r.v = reg_val;
      r.q = '0;
    end else begin
      // Scan from the top so the lowest-index matching channel is the last writer.
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
        if (bus_valid[i] && (bus_tag[i*ROB_ID_W +: ROB_ID_W] == tag)) begin
          r.v = bus_val[i*XLEN +: XLEN];
          hit = 1'b1;
        end
      end
      if (hit) begin
        r.q = '0;
      end else if (rob_rdy) begin
        r.v = rob_val;
        r.q = '0;
      end
    end
    return r;
  endfunction

  always_comb begin
    opnd1 = resolve(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, ready_data1_from_rob,
                    cdb_valid, cdb_rob_id, cdb_result);
    opnd2 = resolve(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, ready_data2_from_rob,
                    cdb_valid, cdb_rob_id, cdb_result);
    if (!dec_use_rs1) opnd1 = '0;
    if (!dec_use_rs2) opnd2 = '0;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy) begin
      if (rollback_flag_from_rob) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Data fields hold between issues; only the strobes return to zero.
  always_comb begin
    out_d = out_q;
    if (rdy) begin
      out_d.ena_rob = 1'b0;
      out_d.ena_reg = 1'b0;
      out_d.ena_rs  = 1'b0;
      out_d.ena_lsb = 1'b0;
      if (can_issue) begin
        out_d.ena_rob = 1'b1;
        out_d.ena_reg = (dec_rd != 5'd0);
        out_d.ena_rs  = ~dec_is_ls;
        out_d.ena_lsb = dec_is_ls;
        out_d.rd      = dec_rd;
        out_d.rob_id  = rob_id_from_rob;
        out_d.openum  = dec_openum;
        out_d.op1     = opnd1;
        out_d.op2     = opnd2;
        out_d.imm     = XLEN'($signed(dec_imm));
        out_d.pc      = iq_pc_q[head_q];
      end
    end
  end

  // NOTE: the queue storage is not reset; head/tail/count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      iq_inst_q[tail_q] <= if_inst;
      iq_pc_q[tail_q]   <= if_pc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign ena_to_rob = out_q.ena_rob;
  assign ena_to_reg = out_q.ena_reg;
  assign ena_to_rs  = out_q.ena_rs;
  assign ena_to_lsb = out_q.ena_lsb;
  assign rd_out     = out_q.rd;
  assign rob_id_out = out_q.rob_id;
  assign openum_out = out_q.openum;
  assign V1_out     = out_q.op1.v;
  assign Q1_out     = out_q.op1.q;
  assign V2_out     = out_q.op2.v;
  assign Q2_out     = out_q.op2.q;
  assign imm_out    = out_q.imm;
  assign pc_out     = out_q.pc;

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rdy && !fifo_empty && !can_issue && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_queue_unit.sv
// Directed and randomized bench for dispatch_queue_unit against a queue-based reference model.
module tb_dispatch_queue_unit;
  import dispatch_queue_unit_pkg::*;

  localparam int XLEN = 32, ROB_ID_W = 4, IQ_DEPTH = 4, NUM_CDB = 2;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  logic if_valid = 0, if_ready;
  logic [31:0] if_inst = '0, if_pc = '0;
  logic rob_full = 0, rs_full = 0, lsb_full = 0, rollback_flag_from_rob = 0;
  logic [4:0] rs1_to_reg, rs2_to_reg, rd_out;
  logic [31:0] V1_from_reg = '0, V2_from_reg = '0, ready_data1_from_rob = '0, ready_data2_from_rob = '0;
  logic [3:0] Q1_from_reg = '0, Q2_from_reg = '0, Q1_to_rob, Q2_to_rob, rob_id_from_rob = '0;
  logic Q1_ready_from_rob = 0, Q2_ready_from_rob = 0;
  logic [1:0] cdb_valid = '0;
  logic [3:0] cdb_id [2] = '{4'd0, 4'd0};
  logic [31:0] cdb_res [2] = '{32'd0, 32'd0};
  logic [7:0] cdb_rob_id;
  logic [63:0] cdb_result;
  logic ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb;
  logic [3:0] rob_id_out, Q1_out, Q2_out;
  logic [OPENUM_W-1:0] openum_out;
  logic [31:0] V1_out, V2_out, imm_out, pc_out;

  assign cdb_rob_id = {cdb_id[1], cdb_id[0]};
  assign cdb_result = {cdb_res[1], cdb_res[0]};

  always #5 clk = ~clk;

  dispatch_queue_unit #(.XLEN(XLEN), .ROB_ID_W(ROB_ID_W), .IQ_DEPTH(IQ_DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(if_ready), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg), .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg), .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
    .ready_data1_from_rob(ready_data1_from_rob), .ready_data2_from_rob(ready_data2_from_rob),
    .rob_id_from_rob(rob_id_from_rob), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
    .ena_to_rob(ena_to_rob), .ena_to_reg(ena_to_reg), .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb),
    .rd_out(rd_out), .rob_id_out(rob_id_out), .openum_out(openum_out), .V1_out(V1_out), .V2_out(V2_out),
    .Q1_out(Q1_out), .Q2_out(Q2_out), .imm_out(imm_out), .pc_out(pc_out),
    .rollback_flag_from_rob(rollback_flag_from_rob)
  );

  typedef struct {
    logic [31:0] inst, pc, imm;
    logic [OPENUM_W-1:0] op;
    logic [4:0] rd, rs1, rs2;
    bit is_ls, u1, u2;
  } ent_t;

  ent_t model_q[$];
  ent_t offered;
  bit e_rob, e_reg, e_rs, e_lsb;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] pc = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the instruction word from its fields; the fields are the expected decode.
  function automatic ent_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] r, input logic [31:0] at);
    ent_t e;
    logic [31:0] im;
    e.pc = at; e.imm = '0; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.is_ls = 0; e.u1 = 1; e.u2 = 0;
    im = {{20{r[11]}}, r[11:0]};
    case (kind)
      0: begin e.op = OP_ADDI; e.imm = im; e.inst = {im[11:0], rs1, 3'b000, rd, 7'h13}; end
      1: begin e.op = OP_LW; e.imm = im; e.is_ls = 1; e.inst = {im[11:0], rs1, 3'b010, rd, 7'h03}; end
      2: begin
        e.op = OP_SW; e.imm = im; e.is_ls = 1; e.u2 = 1; e.rd = 0;
        e.inst = {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
      end
      3: begin e.op = OP_ADD; e.u2 = 1; e.inst = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; end
      4: begin e.op = OP_SUB; e.u2 = 1; e.inst = {7'h20, rs2, rs1, 3'b000, rd, 7'h33}; end
      5: begin
        im = {{19{r[12]}}, r[12:1], 1'b0};
        e.op = OP_BEQ; e.imm = im; e.u2 = 1; e.rd = 0;
        e.inst = {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'h63};
      end
      6: begin
        im = {r[31:12], 12'h0};
        e.op = OP_LUI; e.imm = im; e.u1 = 0; e.inst = {im[31:12], rd, 7'h37};
      end
      default: begin
        im = {{11{r[20]}}, r[20:1], 1'b0};
        e.op = OP_JAL; e.imm = im; e.u1 = 0;
        e.inst = {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
      end
    endcase
    if (!e.u1) e.rs1 = 0;
    if (!e.u2) e.rs2 = 0;
    return e;
  endfunction

  function automatic void model_res(input logic [3:0] tag, input logic [31:0] rv, input bit rr,
                                    input logic [31:0] rdat, output logic [31:0] v, output logic [3:0] q);
    v = '0; q = tag;
    if (tag == 0) begin v = rv; q = 0; return; end
    for (int i = 0; i < NUM_CDB; i++)
      if (cdb_valid[i] && cdb_id[i] == tag) begin v = cdb_res[i]; q = 0; return; end
    if (rr) begin v = rdat; q = 0; end
  endfunction

  task automatic offer(input ent_t e);
    offered = e; if_valid = 1; if_inst = e.inst; if_pc = e.pc; pc = pc + 4;
  endtask

  task automatic offer_zero();
    offered.inst = '0; if_valid = 1; if_inst = '0; if_pc = pc; pc = pc + 4;
  endtask

  task automatic quiet();
    if_valid = 0; rob_full = 0; rs_full = 0; lsb_full = 0; rollback_flag_from_rob = 0; rdy = 1;
    Q1_from_reg = 0; Q2_from_reg = 0; V1_from_reg = 0; V2_from_reg = 0; cdb_valid = 0;
    Q1_ready_from_rob = 0; Q2_ready_from_rob = 0;
  endtask

  // One clock: predicts the edge from current inputs, then checks the registered outputs.
  task automatic cycle();
    bit issue, push;
    ent_t h;
    logic [31:0] ev1, ev2;
    logic [3:0] eq1, eq2, erob;
    issue = 0;
    #1;
    check("if_ready", if_ready, model_q.size() < IQ_DEPTH);
    check("q1_to_rob", Q1_to_rob, Q1_from_reg);
    if (model_q.size() > 0) begin
      check("rs1_to_reg", rs1_to_reg, model_q[0].rs1);
      check("rs2_to_reg", rs2_to_reg, model_q[0].rs2);
    end
    if (rdy) begin
      push = if_valid && (model_q.size() < IQ_DEPTH) && (if_inst != 0) && !rollback_flag_from_rob;
      issue = (model_q.size() > 0) && !rob_full && !rollback_flag_from_rob &&
              (model_q[0].is_ls ? !lsb_full : !rs_full);
      e_rob = 0; e_reg = 0; e_rs = 0; e_lsb = 0;
      if (issue) begin
        h = model_q.pop_front();
        model_res(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, ready_data1_from_rob, ev1, eq1);
        model_res(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, ready_data2_from_rob, ev2, eq2);
        erob = rob_id_from_rob;
        e_rob = 1; e_reg = (h.rd != 0); e_lsb = h.is_ls; e_rs = !h.is_ls;
      end
      if (rollback_flag_from_rob) model_q.delete();
      if (push) model_q.push_back(offered);
    end
    @(posedge clk);
    #1;
    check("ena_to_rob", ena_to_rob, e_rob);
    check("ena_to_reg", ena_to_reg, e_reg);
    check("ena_to_rs", ena_to_rs, e_rs);
    check("ena_to_lsb", ena_to_lsb, e_lsb);
    if (issue) begin
      check("rd_out", rd_out, h.rd);
      check("rob_id_out", rob_id_out, erob);
      check("openum_out", openum_out, h.op);
      check("imm_out", imm_out, h.imm);
      check("pc_out", pc_out, h.pc);
      check("Q1_out", Q1_out, h.u1 ? eq1 : 4'd0);
      check("Q2_out", Q2_out, h.u2 ? eq2 : 4'd0);
      if (h.u1) check("V1_out", V1_out, ev1);
      if (h.u2) check("V2_out", V2_out, ev2);
    end
  endtask

  initial begin
    quiet();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ena_rob", ena_to_rob, 0);
    check("rst_ena_rs", ena_to_rs, 0);
    check("rst_if_ready", if_ready, 1);
    check("rst_rd", rd_out, 0);
    check("rst_v1", V1_out, 0);
    check("rst_pc", pc_out, 0);
    rst_n = 1;

    // ADDI x1,x0,5 at pc 0: strobes one cycle after the push edge
    offer(mk(0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0));
    cycle();
    if_valid = 0;
    cycle();
    check("t1_rs", ena_to_rs, 1); check("t1_rob", ena_to_rob, 1); check("t1_reg", ena_to_reg, 1);
    check("t1_v1", V1_out, 0); check("t1_q1", Q1_out, 0); check("t1_imm", imm_out, 5); check("t1_rd", rd_out, 1);

    // LW with its rs1 tag produced on CDB channel 1
    offer(mk(1, 5'd2, 5'd5, 5'd0, 32'd4, pc));
    cycle();
    if_valid = 0; Q1_from_reg = 3; cdb_valid = 2'b10; cdb_id[1] = 3; cdb_res[1] = 32'h100;
    cycle();
    check("t2_lsb", ena_to_lsb, 1); check("t2_v1", V1_out, 32'h100); check("t2_q1", Q1_out, 0);

    // both channels match: channel 0 wins; then no match and ROB not ready
    quiet();
    offer(mk(0, 5'd3, 5'd6, 5'd0, 32'd1, pc));
    cycle();
    if_valid = 0; Q1_from_reg = 3; cdb_valid = 2'b11; cdb_id[0] = 3; cdb_id[1] = 3;
    cdb_res[0] = 32'hA; cdb_res[1] = 32'hB;
    cycle();
    check("t3_prio", V1_out, 32'hA);
    quiet();
    offer(mk(0, 5'd4, 5'd6, 5'd0, 32'd2, pc));
    cycle();
    if_valid = 0; Q1_from_reg = 3;
    cycle();
    check("t3_wait_q1", Q1_out, 3); check("t3_wait_v1", V1_out, 0);

    // RS back-pressure fills the FIFO, then drains in order
    quiet(); rs_full = 1;
    for (int i = 0; i < 4; i++) begin
      offer(mk(3, 5'(i + 1), 5'd1, 5'd2, 32'd0, 32'h100 + 32'(4 * i)));
      cycle();
    end
    check("t4_full", if_ready, 0);
    check("t4_no_strobe", ena_to_rob, 0);
    if_valid = 0; rs_full = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t4_drain_rs", ena_to_rs, 1);
      check("t4_drain_pc", pc_out, 32'h100 + 32'(4 * i));
    end

    // rollback with three queued entries and a simultaneous push
    rs_full = 1;
    for (int i = 0; i < 3; i++) begin
      offer(mk(0, 5'd7, 5'd1, 5'd0, 32'(i), pc));
      cycle();
    end
    offer(mk(0, 5'd8, 5'd1, 5'd0, 32'd9, pc));
    rollback_flag_from_rob = 1;
    cycle();
    quiet();
    check("t5_empty", if_ready, 1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t5_no_issue", ena_to_rob, 0);
    end

    // zero word dropped; rd=0 ADD issues without a register write
    offer_zero();
    cycle();
    offer(mk(3, 5'd0, 5'd1, 5'd2, 32'd0, pc));
    cycle();
    if_valid = 0;
    cycle();
    check("t6_rs", ena_to_rs, 1); check("t6_reg", ena_to_reg, 0);
    cycle();
    check("t6_zero_dropped", ena_to_rob, 0);

    // rdy low holds a live strobe
    offer(mk(0, 5'd9, 5'd1, 5'd0, 32'd3, pc));
    cycle();
    offer(mk(0, 5'd10, 5'd1, 5'd0, 32'd4, pc));
    cycle();
    if_valid = 0; rdy = 0;
    cycle();
    check("rdy_hold", ena_to_rs, 1);
    rdy = 1;
    cycle();
    check("rdy_resume_rd", rd_out, 10);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 9) == 0) offer_zero();
        else offer(mk(int'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), $urandom, pc));
      end else if_valid = 0;
      rob_full = ($urandom_range(0, 6) == 0);
      rs_full  = ($urandom_range(0, 4) == 0);
      lsb_full = ($urandom_range(0, 4) == 0);
      rollback_flag_from_rob = ($urandom_range(0, 29) == 0);
      Q1_from_reg = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      Q2_from_reg = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      V1_from_reg = $urandom; V2_from_reg = $urandom;
      Q1_ready_from_rob = 1'($urandom_range(0, 1)); Q2_ready_from_rob = 1'($urandom_range(0, 1));
      ready_data1_from_rob = $urandom; ready_data2_from_rob = $urandom;
      rob_id_from_rob = 4'($urandom_range(0, 15));
      cdb_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < NUM_CDB; i++) begin
        cdb_id[i] = 4'($urandom_range(0, 5)); cdb_res[i] = $urandom;
      end
      cycle();
    end

    // asynchronous reset in the middle of activity
    quiet();
    offer(mk(0, 5'd11, 5'd1, 5'd0, 32'd1, pc));
    cycle();
    offer(mk(0, 5'd12, 5'd1, 5'd0, 32'd2, pc));
    rs_full = 0;
    cycle();
    if_valid = 0;
    #2 rst_n = 0;
    #1;
    check("areset_ena", ena_to_rob, 0);
    check("areset_ready", if_ready, 1);
    check("areset_rd", rd_out, 0);
    model_q.delete();
    e_rob = 0; e_reg = 0; e_rs = 0; e_lsb = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
